temp_disp_driver: RTL and testbench

TEMP_DISP_DRIVER -- requirements
Module: temp_disp_driver

---
 rtl/temp_disp_driver_if.sv | 11 +
 rtl/temp_disp_driver.sv | 105 ++++++++++
 tb/tb_temp_disp_driver.sv | 137 +++++++++++++
 3 files changed

// File: rtl/temp_disp_driver_if.sv
// temp_disp_driver_if: temperature strobe input and 2-digit 7-segment display outputs
interface temp_disp_driver_if;
   logic       temp_valid;
   logic [7:0] temp_bin;
   logic       busy;
   logic       ovr;
   logic [1:0] disp;
   logic [7:0] dataSeg;
   modport master (output temp_valid, temp_bin, input busy, ovr, disp, dataSeg);
   modport slave  (input temp_valid, temp_bin, output busy, ovr, disp, dataSeg);
endinterface

// File: rtl/temp_disp_driver.sv
// temp_disp_driver: binary temperature to BCD via double-dabble, multiplexed 2-digit 7-segment drive
module temp_disp_driver #(
   parameter int unsigned REFRESH_DIV = 16
) (
   input logic                SYSCLK,
   input logic                RSTN,
   temp_disp_driver_if.slave  bus
);
   localparam logic [1:0]  IDLE   = 2'd0;
   localparam logic [1:0]  CONV   = 2'd1;
   localparam logic [1:0]  UPDATE = 2'd2;
   localparam logic [15:0] LAST   = 16'(REFRESH_DIV - 1);
   localparam logic [7:0]  DASH   = 8'h40;
   logic [1:0]  state;
   logic [7:0]  sh;
   logic [11:0] bcd;
   logic [11:0] bcd_adj;
   logic [2:0]  it;
   logic [7:0]  msb_q;
   logic [7:0]  lsb_q;
   logic        ovr_q;
   logic [15:0] cnt;
   logic [1:0]  disp_q;
   logic [1:0]  disp_nxt;
   logic        wrap;
   logic [7:0]  seg_q;
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction
   function automatic logic [3:0] dabble(input logic [3:0] n);
      dabble = (n >= 4'd5) ? 4'(n + 4'd3) : n;
   endfunction
   // add-3 correction of every BCD nibble ahead of the shift
   always_comb begin
      bcd_adj = {dabble(bcd[11:8]), dabble(bcd[7:4]), dabble(bcd[3:0])};
   end
   // conversion FSM: capture, eight shift iterations, then load the display registers
   always_ff @(posedge SYSCLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
         sh    <= '0;
         bcd   <= '0;
         it    <= '0;
         msb_q <= '0;
         lsb_q <= '0;
         ovr_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.temp_valid) begin
                  sh    <= bus.temp_bin;
                  bcd   <= '0;
                  it    <= '0;
                  state <= CONV;
               end
            end
            CONV: begin
               {bcd, sh} <= {bcd_adj[10:0], sh, 1'b0};
               it        <= it + 3'd1;
               state     <= (it == 3'd7) ? UPDATE : CONV;
            end
            UPDATE: begin
               ovr_q <= (bcd[11:8] != 4'd0);
               msb_q <= (bcd[11:8] != 4'd0) ? DASH : (bcd[7:4] == 4'd0) ? 8'h00 : {1'b0, seg7(bcd[7:4])};
               lsb_q <= (bcd[11:8] != 4'd0) ? DASH : {1'b0, seg7(bcd[3:0])};
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // refresh divider and digit selection run free of the conversion FSM
   always_comb begin
      wrap     = (cnt == LAST);
      disp_nxt = wrap ? ~disp_q : disp_q;
   end
   // digit mux: segments follow the digit that disp selects on the same edge
   always_ff @(posedge SYSCLK or negedge RSTN) begin
      if (!RSTN) begin
         cnt    <= '0;
         disp_q <= 2'b01;
         seg_q  <= '0;
      end else begin
         cnt    <= wrap ? 16'd0 : cnt + 16'd1;
         disp_q <= disp_nxt;
         seg_q  <= disp_nxt[1] ? msb_q : lsb_q;
      end
   end
   assign bus.busy    = (state != IDLE);
   assign bus.ovr     = ovr_q;
   assign bus.disp    = disp_q;
   assign bus.dataSeg = seg_q;
endmodule

// File: tb/tb_temp_disp_driver.sv
// tb_temp_disp_driver: directed vectors for temp_disp_driver with REFRESH_DIV=4
module tb_temp_disp_driver;
   logic SYSCLK = 1'b0;
   logic RSTN   = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   temp_disp_driver_if bus();
   temp_disp_driver #(.REFRESH_DIV(4)) dut (.SYSCLK(SYSCLK), .RSTN(RSTN), .bus(bus));
   always #5 SYSCLK = ~SYSCLK;
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(negedge SYSCLK);
   endtask
   task automatic strobe(input logic [7:0] v);
      bus.temp_valid = 1'b1;
      bus.temp_bin   = v;
      tick();
      bus.temp_valid = 1'b0;
   endtask
   task automatic wait_disp(input logic [1:0] d);
      int k = 0;
      while (bus.disp !== d && k < 10) begin
         tick();
         k++;
      end
      chk("disp_reach", {6'b0, bus.disp}, {6'b0, d});
   endtask
   task automatic show(input logic [7:0] msb, input logic [7:0] lsb, input logic o);
      wait_disp(2'b10);
      chk("msb_slot", bus.dataSeg, msb);
      wait_disp(2'b01);
      chk("lsb_slot", bus.dataSeg, lsb);
      chk("ovr", {7'b0, bus.ovr}, {7'b0, o});
   endtask
   task automatic conv(input logic [7:0] v, input logic [7:0] msb, input logic [7:0] lsb, input logic o);
      int n = 0;
      strobe(v);
      repeat (12) begin
         if (bus.busy) n++;
         tick();
      end
      chk("busy_len", 8'(n), 8'd9);
      show(msb, lsb, o);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int nb;
      int ns;
      bus.temp_valid = 1'b0;
      bus.temp_bin   = 8'h00;
      @(posedge SYSCLK);
      #1;
      chk("rst_busy", {7'b0, bus.busy}, 8'h00);
      chk("rst_ovr", {7'b0, bus.ovr}, 8'h00);
      chk("rst_disp", {6'b0, bus.disp}, 8'h01);
      chk("rst_seg", bus.dataSeg, 8'h00);
      tick();
      RSTN = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk("refresh_disp", {6'b0, bus.disp}, ((i / 4) % 2 == 1) ? 8'h02 : 8'h01);
         chk("refresh_blank", bus.dataSeg, 8'h00);
         tick();
      end
      conv(8'h17, 8'h5B, 8'h4F, 1'b0);
      conv(8'h05, 8'h00, 8'h6D, 1'b0);
      conv(8'h00, 8'h00, 8'h3F, 1'b0);
      conv(8'h63, 8'h6F, 8'h6F, 1'b0);
      conv(8'h64, 8'h40, 8'h40, 1'b1);
      conv(8'hFF, 8'h40, 8'h40, 1'b1);
      strobe(8'h17);
      tick();
      tick();
      bus.temp_valid = 1'b1;
      bus.temp_bin   = 8'h2A;
      tick();
      bus.temp_valid = 1'b0;
      repeat (10) tick();
      chk("ignore_busy", {7'b0, bus.busy}, 8'h00);
      show(8'h5B, 8'h4F, 1'b0);
      conv(8'h2A, 8'h66, 8'h5B, 1'b0);
      strobe(8'h05);
      repeat (8) tick();
      chk("update_busy", {7'b0, bus.busy}, 8'h01);
      bus.temp_valid = 1'b1;
      bus.temp_bin   = 8'h63;
      tick();
      bus.temp_valid = 1'b0;
      chk("edge_ign0", {7'b0, bus.busy}, 8'h00);
      tick();
      chk("edge_ign1", {7'b0, bus.busy}, 8'h00);
      show(8'h00, 8'h6D, 1'b0);
      conv(8'hFF, 8'h40, 8'h40, 1'b1);
      strobe(8'h30);
      repeat (4) tick();
      #1;
      RSTN = 1'b0;
      #1;
      chk("abort_busy", {7'b0, bus.busy}, 8'h00);
      chk("abort_ovr", {7'b0, bus.ovr}, 8'h00);
      chk("abort_disp", {6'b0, bus.disp}, 8'h01);
      chk("abort_seg", bus.dataSeg, 8'h00);
      tick();
      RSTN = 1'b1;
      nb = 0;
      ns = 0;
      repeat (15) begin
         if (bus.busy) nb++;
         if (bus.dataSeg != 8'h00) ns++;
         tick();
      end
      chk("post_abort_busy", 8'(nb), 8'd0);
      chk("post_abort_seg", 8'(ns), 8'd0);
      chk("post_abort_ovr", {7'b0, bus.ovr}, 8'h00);
      RSTN = 1'b0;
      tick();
      RSTN = 1'b1;
      bus.temp_valid = 1'b1;
      bus.temp_bin   = 8'h09;
      tick();
      bus.temp_valid = 1'b0;
      chk("first_edge_accept", {7'b0, bus.busy}, 8'h01);
      repeat (12) tick();
      show(8'h00, 8'h6F, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
